uart_receiver: RTL and testbench

Receive side of the system UART, the counterpart of `uart_transmitter` / `uart_transmitter_interface`. It samples the asynchronous `rx` pin, deframes 8N1 bytes LSB-first into a small FIFO, and exposes data and sticky error status on the CPU system bus as a read-data-valid slave. It sits beside the transmitter interface in the top level and decodes one address bit from `system_bus`.

---
 rtl/uart_receiver.sv | 217 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with a small byte FIFO and a
// read-data-valid bus slave exposing DATA (addr=0) and STATUS (addr=1).
module uart_receiver #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       addr,
  input  logic [7:0] write_data,
  input  logic       byte_enable,
  input  logic       write_req,
  input  logic       read_req,
  output logic [8:0] read_data,
  output logic       read_data_valid,
  input  logic       rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Line synchronizer
  logic rx_meta_q, rxs_q;

  // Deframer
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push;
  logic             ferr_set;

  // FIFO
  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic                       full, nonempty, pop, push_ok, ovr_set;

  // Status flags and bus outputs
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       status_wr;
  logic [8:0] read_data_q, read_data_d;
  logic       read_data_valid_q, read_data_valid_d;

  // Only write_data[3:2] carry meaning; the rest is intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^{write_data[7:4], write_data[1:0]};

  // Two-flop synchronizer; idles high so reset looks like an idle line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Deframer next-state: start is re-checked at mid-bit, then every bit is
  // sampled one full bit period after the previous sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF_M1) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL_M1) begin
          shreg_d[idx_q] = rxs_q;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        // A line held low reports one framing error, not one per frame time.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full      = count_q[FIFO_DEPTH_BITS];
  assign nonempty  = |count_q;
  assign pop       = read_req && !addr && nonempty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push && (!full || pop);
  assign ovr_set   = push && full && !pop;
  assign status_wr = write_req && addr && byte_enable;

  // FIFO pointers/count, sticky flags and registered bus response.
  always_comb begin
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    read_data_d       = read_data_q;
    read_data_valid_d = read_req;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set wins over a clear arriving in the same cycle.
    ovr_d  = ovr_set  | (ovr_q  & ~(status_wr & write_data[2]));
    ferr_d = ferr_set | (ferr_q & ~(status_wr & write_data[3]));
    if (read_req) begin
      if (addr) begin
        read_data_d = {5'b0, ferr_q, ovr_q, full, nonempty};
      end else if (nonempty) begin
        read_data_d = {1'b1, mem_q[rd_ptr_q]};
      end else begin
        read_data_d = 9'h000;
      end
    end
  end

  // FIFO storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  // All control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      idx_q             <= '0;
      shreg_q           <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      ovr_q             <= 1'b0;
      ferr_q            <= 1'b0;
      read_data_q       <= '0;
      read_data_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      idx_q             <= idx_d;
      shreg_q           <= shreg_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      ovr_q             <= ovr_d;
      ferr_q            <= ferr_d;
      read_data_q       <= read_data_d;
      read_data_valid_q <= read_data_valid_d;
    end
  end

  assign read_data       = read_data_q;
  assign read_data_valid = read_data_valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives 8N1 frames and bus accesses; a queue-based
// reference model predicts each read and a monitor checks the responses.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       byte_enable = 1'b0;
  logic       write_req = 1'b0;
  logic       read_req = 1'b0;
  logic [8:0] read_data;
  logic       read_data_valid;
  logic       rx = 1'b1;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH_BITS(3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .addr           (addr),
    .write_data     (write_data),
    .byte_enable    (byte_enable),
    .write_req      (write_req),
    .read_req       (read_req),
    .read_data      (read_data),
    .read_data_valid(read_data_valid),
    .rx             (rx)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] data;
    int         cycle;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: received bytes in arrival order plus the two sticky flags.
  logic [7:0] mq[$];
  bit m_ovr = 1'b0;
  bit m_ferr = 1'b0;

  function automatic logic [8:0] model_status();
    return {5'b0, m_ferr, m_ovr, (mq.size() == 8), (mq.size() != 0)};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 9'h%03h expected 9'h%03h", name, act, exp);
    end else begin
      $display("ok   %s: 9'h%03h", name, act);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read, on time.
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n) begin
      if (read_data_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got valid with data 9'h%03h, required no response", read_data);
        end else begin
          mon_e = sb_q.pop_front();
          check(mon_e.name, read_data, mon_e.data);
          checks++;
          if (cyc != mon_e.cycle) begin
            failures++;
            $display("FAIL %s_latency: valid at cycle %0d, required cycle %0d", mon_e.name, cyc, mon_e.cycle);
          end
        end
      end else if (sb_q.size() != 0 && cyc >= sb_q[0].cycle) begin
        mon_e = sb_q.pop_front();
        checks++;
        failures++;
        $display("FAIL %s_missing: no valid at cycle %0d, required valid", mon_e.name, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic a, input string name);
    exp_t e;
    addr     = a;
    read_req = 1'b1;
    e.name   = name;
    e.cycle  = cyc + 1;
    if (a) e.data = model_status();
    else if (mq.size() > 0) e.data = {1'b1, mq.pop_front()};
    else e.data = 9'h000;
    sb_q.push_back(e);
    tick(1);
    read_req = 1'b0;
    addr     = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] wd, input logic be);
    addr        = a;
    write_data  = wd;
    byte_enable = be;
    write_req   = 1'b1;
    if (a && be) begin
      if (wd[2]) m_ovr = 1'b0;
      if (wd[3]) m_ferr = 1'b0;
    end
    tick(1);
    write_req   = 1'b0;
    byte_enable = 1'b0;
    addr        = 1'b0;
  endtask

  // One 8N1 frame; a bad stop bit is followed by 40 more low cycles.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    if (stop_ok) begin
      if (mq.size() < 8) mq.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
      tick(40);
      rx = 1'b1;
      tick(4);
    end
    rx = 1'b1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    logic [7:0] pb;
    int         r;

    // Reset state
    tick(3);
    check("reset_rdata", read_data, 9'h000);
    check("reset_valid", {8'h00, read_data_valid}, 9'h000);
    reset_n = 1'b1;
    tick(3);

    // Single byte
    send_byte(8'hA5, 1'b1);
    bus_read(1'b1, "single_status");
    bus_read(1'b0, "single_data");
    bus_read(1'b1, "single_status_after");

    // Glitch shorter than half a bit, then a good byte to prove IDLE
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    bus_read(1'b1, "glitch_status");
    send_byte(8'hC3, 1'b1);
    bus_read(1'b0, "glitch_follow_data");

    // Framing error with a held-low line
    send_byte(8'h3C, 1'b0);
    bus_read(1'b1, "ferr_status");
    bus_read(1'b0, "ferr_data_empty");
    bus_write(1'b1, 8'h08, 1'b1);
    bus_read(1'b1, "ferr_cleared");

    // Overflow: nine back-to-back frames, no reads
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1);
    bus_read(1'b1, "ovr_status");
    for (int i = 0; i < 9; i++) bus_read(1'b0, $sformatf("ovr_data%0d", i));
    bus_write(1'b1, 8'h04, 1'b1);
    bus_read(1'b1, "ovr_cleared");

    // Read lands in the same cycle as a push into a full FIFO
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
    fork
      send_byte(8'h18, 1'b1);
      begin
        tick(2 + 1 + CPB / 2 + 9 * CPB - 1);
        bus_read(1'b0, "conc_data");
      end
    join
    bus_read(1'b1, "conc_status");
    for (int i = 0; i < 8; i++) bus_read(1'b0, $sformatf("conc_drain%0d", i));

    // Reset in the middle of data bit 4 with a stale byte in the FIFO
    send_byte(8'h77, 1'b1);
    bus_read(1'b1, "prereset_status");
    tick(3);
    pb = 8'hE1;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      tick(CPB);
    end
    rx = pb[4];
    tick(CPB / 2);
    reset_n = 1'b0;
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    #1;
    check("midreset_rdata", read_data, 9'h000);
    check("midreset_valid", {8'h00, read_data_valid}, 9'h000);
    rx = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    send_byte(8'h5A, 1'b1);
    bus_read(1'b1, "postreset_status");
    bus_read(1'b0, "postreset_data");
    bus_read(1'b0, "postreset_empty");

    // Randomized mix of frames and bus traffic
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        rb = 8'($urandom);
        send_byte(rb, $urandom_range(0, 7) != 0);
      end else if (r <= 5) begin
        bus_read(1'b0, $sformatf("rand%0d_data", n));
      end else if (r <= 7) begin
        bus_read(1'b1, $sformatf("rand%0d_status", n));
      end else if (r == 8) begin
        bus_write(1'b1, 8'($urandom), 1'($urandom));
      end else begin
        bus_write(1'b0, 8'($urandom), 1'b1);
      end
      tick(int'($urandom_range(0, 3)));
    end
    bus_read(1'b1, "final_status");
    for (int i = 0; i < 9; i++) bus_read(1'b0, $sformatf("final_drain%0d", i));

    tick(5);
    check("scoreboard_drained", 9'(sb_q.size()), 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
